// File: rtl/squash_input_conditioner_if.sv
// rtl/squash_input_conditioner_if.sv - button/control bundle between board buttons and the squash conditioner
//
// Purpose: carries the four raw player buttons and the four conditioned
// controls that feed the solo_squash game core.
//
// Signals (all active low):
//   btn_pause_n, btn_new_game_n, btn_down_n, btn_up_n : raw, asynchronous buttons
//   pause_n, new_game_n, down_key_n, up_key_n          : conditioned, clk-synchronous controls
//
// Modports:
//   master : board/stimulus side, drives the raw buttons, observes the controls
//   slave  : conditioner side, receives the raw buttons, drives the controls
interface squash_input_conditioner_if;
  logic btn_pause_n;
  logic btn_new_game_n;
  logic btn_down_n;
  logic btn_up_n;
  logic pause_n;
  logic new_game_n;
  logic down_key_n;
  logic up_key_n;

  modport master (
    output btn_pause_n,
    output btn_new_game_n,
    output btn_down_n,
    output btn_up_n,
    input  pause_n,
    input  new_game_n,
    input  down_key_n,
    input  up_key_n
  );

  modport slave (
    input  btn_pause_n,
    input  btn_new_game_n,
    input  btn_down_n,
    input  btn_up_n,
    output pause_n,
    output new_game_n,
    output down_key_n,
    output up_key_n
  );
endinterface

// File: rtl/squash_input_conditioner.sv
// rtl/squash_input_conditioner.sv - synchronise, debounce and arbitrate the solo_squash player buttons
//
// Purpose: turns four bouncy asynchronous active-low buttons into clean
// synchronous active-low controls for the game core. Every button goes
// through a SYNC_STAGES-deep synchroniser and a tick-based debouncer that
// needs DEBOUNCE_TICKS consecutive differing ticks to accept a new level.
// Pressing up and down together produces no motion.
//
// Optional feature macro: SQUASH_PAUSE_TOGGLE_EN
//   defined   : a debounced pause press toggles a paused register, a debounced
//               new-game press clears it (clear wins), pause_n = ~paused.
//   undefined : pause_n follows the debounced pause button (hold to pause).
//
// Ports:
//   clk   : 25 MHz pixel clock shared with the game core
//   reset : asynchronous, active-high reset
//   io    : squash_input_conditioner_if.slave (raw buttons in, controls out)
module squash_input_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int TICK_DIV       = 25000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  squash_input_conditioner_if.slave     io
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS);

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_TICKS - 1);

  localparam int BTN_PAUSE = 0;
  localparam int BTN_NEW   = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;

  logic [3:0] raw;
  logic [3:0] sample;
  logic [3:0] stable;
  logic [3:0] accept;

  assign raw = {io.btn_up_n, io.btn_down_n, io.btn_new_game_n, io.btn_pause_n};

  // Shared sample-tick prescaler: one tick every TICK_DIV clocks.
  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_q;
    logic [CW-1:0]          c_q;

    // Reset to 1 so a released button never looks pressed after reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q <= '1;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[i]};
      end
    end

    assign sample[i] = sync_q[SYNC_STAGES-1];

    // c_q counts ticks seen since the sample last agreed with the stable
    // state; the tick that would take it past CNT_LAST accepts the change.
    assign accept[i] = (sample[i] != s_q) && tick && (c_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s_q <= 1'b1;
        c_q <= '0;
      end else if (sample[i] == s_q) begin
        c_q <= '0;
      end else if (accept[i]) begin
        s_q <= sample[i];
        c_q <= '0;
      end else if (tick) begin
        c_q <= c_q + 1'b1;
      end
    end

    assign stable[i] = s_q;
  end

  logic both_pressed;
  assign both_pressed = ~stable[BTN_UP] & ~stable[BTN_DOWN];

`ifdef SQUASH_PAUSE_TOGGLE_EN
  // An accept with a low sample is exactly the cycle the stable state
  // falls 1->0, i.e. a debounced press.
  logic paused_q;
  logic pause_press;
  logic new_press;

  assign pause_press = accept[BTN_PAUSE] & ~sample[BTN_PAUSE];
  assign new_press   = accept[BTN_NEW]   & ~sample[BTN_NEW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paused_q <= 1'b0;
    end else if (new_press) begin
      paused_q <= 1'b0;
    end else if (pause_press) begin
      paused_q <= ~paused_q;
    end
  end
`endif

  logic pause_q;
  logic new_q;
  logic down_q;
  logic up_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pause_q <= 1'b1;
      new_q   <= 1'b1;
      down_q  <= 1'b1;
      up_q    <= 1'b1;
    end else begin
`ifdef SQUASH_PAUSE_TOGGLE_EN
      pause_q <= ~paused_q;
`else
      pause_q <= stable[BTN_PAUSE];
`endif
      new_q   <= stable[BTN_NEW];
      // Both directions held cancel out; releasing one lets the other
      // through on the next cycle.
      down_q  <= both_pressed | stable[BTN_DOWN];
      up_q    <= both_pressed | stable[BTN_UP];
    end
  end

  assign io.pause_n    = pause_q;
  assign io.new_game_n = new_q;
  assign io.down_key_n = down_q;
  assign io.up_key_n   = up_q;

endmodule

// File: tb/tb_squash_input_conditioner.sv
// tb/tb_squash_input_conditioner.sv - self-checking bench for squash_input_conditioner
module tb_squash_input_conditioner;
  localparam int SYNC = 2;
  localparam int TDIV = 4;
  localparam int DEB  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] raw = 4'b1111;  // {up, down, new_game, pause}

  always #5 clk = ~clk;

  squash_input_conditioner_if bus();

  assign bus.btn_pause_n    = raw[0];
  assign bus.btn_new_game_n = raw[1];
  assign bus.btn_down_n     = raw[2];
  assign bus.btn_up_n       = raw[3];

  squash_input_conditioner #(
    .SYNC_STAGES(SYNC),
    .TICK_DIV(TDIV),
    .DEBOUNCE_TICKS(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(bus)
  );

  logic [3:0] dut_out;
  assign dut_out = {bus.up_key_n, bus.down_key_n, bus.new_game_n, bus.pause_n};

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model. Edges are numbered from reset release; the sample tick
  // is active at edge e when e is a multiple of TDIV. A button's new level is
  // accepted once DEB ticks have passed since the last edge at which its
  // synchronised sample agreed with the accepted level.
  bit         m_q[4][$];
  int         m_edge;
  int         m_last[4];
  bit         m_s[4];
  logic [3:0] m_out;
  bit         m_paused;

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      m_q[b].delete();
      for (int k = 0; k < SYNC; k++) m_q[b].push_back(1'b1);
      m_last[b] = 0;
      m_s[b]    = 1'b1;
    end
    m_edge   = 0;
    m_out    = 4'b1111;
    m_paused = 1'b0;
  endtask

  task automatic model_edge();
    bit         smp;
    bit         fell[4];
    logic [3:0] nxt;
    m_edge++;
    nxt[1] = m_s[1];
    if (!m_s[3] && !m_s[2]) begin
      nxt[3] = 1'b1;
      nxt[2] = 1'b1;
    end else begin
      nxt[3] = m_s[3];
      nxt[2] = m_s[2];
    end
`ifdef SQUASH_PAUSE_TOGGLE_EN
    nxt[0] = ~m_paused;
`else
    nxt[0] = m_s[0];
`endif
    for (int b = 0; b < 4; b++) begin
      smp = m_q[b].pop_front();
      m_q[b].push_back(raw[b]);
      fell[b] = 1'b0;
      if (smp == m_s[b]) begin
        m_last[b] = m_edge;
      end else if ((m_edge % TDIV == 0) && (m_edge / TDIV - m_last[b] / TDIV >= DEB)) begin
        m_s[b]    = smp;
        m_last[b] = m_edge;
        fell[b]   = (smp == 1'b0);
      end
    end
`ifdef SQUASH_PAUSE_TOGGLE_EN
    if (fell[1]) m_paused = 1'b0;
    else if (fell[0]) m_paused = ~m_paused;
`endif
    m_out = nxt;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      model_edge();
      check("model_cycle", dut_out, m_out);
    end
  endtask

  typedef struct {
    logic [3:0] btn;
    int         hold;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    bit saw_low;
    int falls, rises, low_cnt;
    logic prev;
    int   dur[4];

    tbl[0]  = '{4'b1111, 20, 4'b1111};
    tbl[1]  = '{4'b1011, 20, 4'b1011};
    tbl[2]  = '{4'b0011, 20, 4'b1111};
    tbl[3]  = '{4'b0111, 20, 4'b0111};
    tbl[4]  = '{4'b1111, 20, 4'b1111};
    tbl[5]  = '{4'b1101, 20, 4'b1101};
    tbl[6]  = '{4'b1100, 20, 4'b1100};
`ifdef SQUASH_PAUSE_TOGGLE_EN
    tbl[7]  = '{4'b1101, 20, 4'b1100};
    tbl[8]  = '{4'b1111, 20, 4'b1110};
    tbl[9]  = '{4'b1110, 20, 4'b1111};
    tbl[10] = '{4'b1111, 20, 4'b1111};
    tbl[11] = '{4'b1110, 20, 4'b1110};
    tbl[12] = '{4'b1111, 20, 4'b1110};
`else
    tbl[7]  = '{4'b1101, 20, 4'b1101};
    tbl[8]  = '{4'b1111, 20, 4'b1111};
    tbl[9]  = '{4'b1110, 20, 4'b1110};
    tbl[10] = '{4'b1111, 20, 4'b1111};
    tbl[11] = '{4'b1110, 20, 4'b1110};
    tbl[12] = '{4'b1111, 20, 4'b1111};
`endif
    tbl[13] = '{4'b1101, 20, 4'b1101};
    tbl[14] = '{4'b1111, 20, 4'b1111};

    // Reset state.
    model_reset();
    #1 reset = 1'b1;
    #2 check("reset_state", dut_out, 4'b1111);
    @(posedge clk);
    #1 reset = 1'b0;

    // Async reset mid-count with everything pressed.
    raw = 4'b0000;
    step(8);
    #3 reset = 1'b1;
    #1 check("async_reset", dut_out, 4'b1111);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    step(12);
    check("fresh_debounce_hold", dut_out, 4'b1111);
    step(1);
`ifdef SQUASH_PAUSE_TOGGLE_EN
    check("fresh_debounce_done", dut_out, 4'b1101);
`else
    check("fresh_debounce_done", dut_out, 4'b1100);
`endif
    raw = 4'b1111;
    step(20);

    // Table of held levels.
    for (int i = 0; i < 15; i++) begin
      raw = tbl[i].btn;
      step(tbl[i].hold);
      check($sformatf("table_%0d", i), dut_out, tbl[i].exp);
    end

    // Bounce rejection at every tick phase, then an accepted 13-clock pulse.
    saw_low = 1'b0;
    for (int off = 0; off < TDIV; off++) begin
      step(off);
      raw = 4'b0111;
      for (int k = 0; k < 8; k++) begin
        step(1);
        if (bus.up_key_n == 1'b0) saw_low = 1'b1;
      end
      raw = 4'b1111;
      for (int k = 0; k < 16; k++) begin
        step(1);
        if (bus.up_key_n == 1'b0) saw_low = 1'b1;
      end
    end
    check("bounce_reject", saw_low, 0);
    raw = 4'b0111;
    for (int k = 0; k < 13; k++) begin
      step(1);
      if (bus.up_key_n == 1'b0) saw_low = 1'b1;
    end
    raw = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (bus.up_key_n == 1'b0) saw_low = 1'b1;
    end
    check("long_pulse_accept", saw_low, 1);
    step(20);

    // new_game held 40 clocks: one clean low window of about the held length.
    falls = 0; rises = 0; low_cnt = 0;
    prev = bus.new_game_n;
    raw = 4'b1101;
    for (int k = 0; k < 70; k++) begin
      if (k == 40) raw = 4'b1111;
      step(1);
      if (prev == 1'b1 && bus.new_game_n == 1'b0) falls++;
      if (prev == 1'b0 && bus.new_game_n == 1'b1) rises++;
      if (bus.new_game_n == 1'b0) low_cnt++;
      prev = bus.new_game_n;
    end
    check("new_game_falls", falls, 1);
    check("new_game_rises", rises, 1);
    check("new_game_low_min", int'(low_cnt >= 40 - TDIV * DEB), 1);
    check("new_game_low_max", int'(low_cnt <= 40 + TDIV * DEB), 1);

    // Random bouncy buttons against the model.
    for (int b = 0; b < 4; b++) dur[b] = $urandom_range(1, 24);
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 4; b++) begin
        dur[b]--;
        if (dur[b] <= 0) begin
          raw[b] = ~raw[b];
          dur[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 40)) : int'($urandom_range(1, 10));
        end
      end
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
